// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: sequences an external CNT_W-bit up-counter through lo..hi
// sweeps for a programmed number of passes. It supports pause, abort and a
// start/done handshake. Every output except cnt_en is registered; cnt_en is
// combinational so that the counter stops on the same cycle as stop/pause/hi.
module count_seq_ctrl #(
  parameter int CNT_W  = 3,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [CNT_W-1:0]  lo,
  input  logic [CNT_W-1:0]  hi,
  input  logic [PASS_W-1:0] passes,
  input  logic [CNT_W-1:0]  count,
  output logic              cnt_en,
  output logic              cnt_load,
  output logic [CNT_W-1:0]  cnt_load_val,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err,
  output logic [PASS_W-1:0] pass_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [PASS_W-1:0] PASS_ZERO = {PASS_W{1'b0}};
  localparam logic [PASS_W-1:0] PASS_ONE  = PASS_W'(1);
  localparam logic [PASS_W-1:0] PASS_MAX  = {PASS_W{1'b1}};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    lo_q, lo_d;
  logic [CNT_W-1:0]    hi_q, hi_d;
  logic [PASS_W-1:0]   passes_q, passes_d;
  logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [PASS_W-1:0]   pass_inc_s;
  logic                aborted_q, aborted_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cnt_load_q, cnt_load_d;

  // Saturating increment of the completed-pass counter.
  assign pass_inc_s = (pass_cnt_q == PASS_MAX) ? PASS_MAX : (pass_cnt_q + PASS_ONE);

  // Counter enable: only while sweeping, not stopped or paused, and short of hi.
  assign cnt_en = (state_q == S_RUN) && !stop && !pause && (count != hi_q);

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    passes_d   = passes_q;
    pass_cnt_d = pass_cnt_q;
    aborted_d  = aborted_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (lo <= hi) begin
            lo_d       = lo;
            hi_d       = hi;
            passes_d   = (passes == PASS_ZERO) ? PASS_ONE : passes;
            pass_cnt_d = PASS_ZERO;
            aborted_d  = 1'b0;
            state_d    = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (count == hi_q) begin
          pass_cnt_d = pass_inc_s;
          state_d    = (pass_inc_s == passes_q) ? S_DONE : S_LOAD;
        end else begin
          state_d = S_RUN;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (!pause) begin
          state_d = S_RUN;
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    busy_d     = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_PAUSE);
    done_d     = (state_d == S_DONE);
    cnt_load_d = (state_d == S_LOAD);
  end

  // State, captured sweep parameters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lo_q       <= {CNT_W{1'b0}};
      hi_q       <= {CNT_W{1'b0}};
      passes_q   <= PASS_ZERO;
      pass_cnt_q <= PASS_ZERO;
      aborted_q  <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      passes_q   <= passes_d;
      pass_cnt_q <= pass_cnt_d;
      aborted_q  <= aborted_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_load_q <= cnt_load_d;
    end
  end

  assign cnt_load     = cnt_load_q;
  assign cnt_load_val = lo_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign err          = err_q;
  assign pass_cnt     = pass_cnt_q;

endmodule
